// File: rtl/serdes_prbs_bist_pkg.sv
// Shared encodings and helpers for the PRBS BIST engine: polynomial modes,
// checker states, per-mode LFSR order/taps and a popcount for error tallying.
package serdes_bist_pkg;

    localparam int unsigned LFSR_W = 31;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS15 = 2'd1,
        MODE_PRBS31 = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic [4:0] tap_a;
        logic [4:0] tap_b;
    } taps_t;

    // Reserved mode falls back to PRBS7.
    function automatic int unsigned prbs_order(input mode_e m);
        case (m)
            MODE_PRBS15: return 15;
            MODE_PRBS31: return 31;
            default:     return 7;
        endcase
    endfunction

    function automatic taps_t prbs_taps(input mode_e m);
        case (m)
            MODE_PRBS15: return '{tap_a: 5'd14, tap_b: 5'd13};
            MODE_PRBS31: return '{tap_a: 5'd30, tap_b: 5'd27};
            default:     return '{tap_a: 5'd6,  tap_b: 5'd5};
        endcase
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [31:0] t;
        logic [5:0]  n;
        t = v;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + {5'd0, t[0]};
            t = t >> 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/serdes_prbs_bist_if.sv
// Parallel word link between the BIST engine and the SerDes serializer/deserializer.
interface serdes_prbs_bist_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport master (
        output tx_data,
        output tx_valid,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/serdes_prbs_bist_lfsr_adv.sv
// Combinational DATA_W-step advance of a Fibonacci LFSR; the first generated
// bit lands in the word MSB.
module prbs_lfsr_adv
    import serdes_bist_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [LFSR_W-1:0] state_i,
    input  mode_e             mode_i,
    output logic [LFSR_W-1:0] state_o,
    output logic [DATA_W-1:0] word_o
);

    taps_t             taps;
    logic [LFSR_W-1:0] s;
    logic [DATA_W-1:0] w;
    logic              fb;

    always_comb begin
        taps = prbs_taps(mode_i);
        s    = state_i;
        w    = '0;
        fb   = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            fb = s[taps.tap_a] ^ s[taps.tap_b];
            s  = {s[LFSR_W-2:0], fb};
            w  = {w[DATA_W-2:0], fb};
        end
        state_o = s;
        word_o  = w;
    end

endmodule

// File: rtl/serdes_prbs_bist.sv
// PRBS BIST engine: pattern generator for the TX path plus a self-seeding
// checker with lock/loss hysteresis and a saturating bit-error counter.
module serdes_prbs_bist
    import serdes_bist_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ERR_CNT_W   = 16,
    parameter int unsigned LOCK_THRESH = 8,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [1:0]           mode,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 inject_err,
    serdes_prbs_bist_if.master   lnk,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sat,
    output logic [1:0]           state
);

    localparam int unsigned GOOD_W = $clog2(LOCK_THRESH + 1);
    localparam int unsigned BAD_W  = $clog2(LOSS_THRESH + 1);
    localparam int unsigned SUM_W  = ((ERR_CNT_W > 6) ? ERR_CNT_W : 6) + 1;
    localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'({ERR_CNT_W{1'b1}});

    mode_e                mode_q, mode_d, gen_mode;
    logic [LFSR_W-1:0]    gen_q, gen_d, gen_seed, gen_next;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d, gen_word, inj_mask;
    logic                 tx_valid_q, tx_valid_d;

    chk_state_e           state_q, state_d;
    logic [LFSR_W-1:0]    chk_q, chk_d, chk_next, chk_seed;
    logic [DATA_W-1:0]    pred_word;
    logic [2:0]           seed_cnt_q, seed_cnt_d, seed_last;
    logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]     bad_cnt_q, bad_cnt_d;
    logic                 locked_q, locked_d;
    logic                 err_sat_q, err_sat_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [5:0]           err_bits;
    logic [SUM_W-1:0]     err_sum;
    logic                 go, rx_step, mismatch, seed_done, lock_hit, loss_hit;

    // Start reseeds the generator in the same cycle, so one advance unit serves both paths.
    assign go       = start & ~stop;
    assign rx_step  = lnk.rx_valid & ~start & ~stop;
    assign gen_seed = go ? '1 : gen_q;
    assign gen_mode = go ? mode_e'(mode) : mode_q;
    assign inj_mask = DATA_W'(inject_err & tx_valid_q);

    prbs_lfsr_adv #(.DATA_W(DATA_W)) u_gen_adv (
        .state_i (gen_seed),
        .mode_i  (gen_mode),
        .state_o (gen_next),
        .word_o  (gen_word)
    );

    prbs_lfsr_adv #(.DATA_W(DATA_W)) u_chk_adv (
        .state_i (chk_q),
        .mode_i  (mode_q),
        .state_o (chk_next),
        .word_o  (pred_word)
    );

    // Received bits are the generator's feedback bits, so shifting them in rebuilds its state.
    assign chk_seed  = LFSR_W'({chk_q, lnk.rx_data});
    assign mismatch  = (lnk.rx_data != pred_word);
    assign err_bits  = popcount(32'(lnk.rx_data ^ pred_word));
    assign err_sum   = SUM_W'(err_cnt_q) + SUM_W'(err_bits);
    assign seed_last = 3'((prbs_order(mode_q) + DATA_W - 1) / DATA_W - 1);
    assign seed_done = (seed_cnt_q == seed_last);
    assign lock_hit  = (good_cnt_q == GOOD_W'(LOCK_THRESH - 1));
    assign loss_hit  = (bad_cnt_q == BAD_W'(LOSS_THRESH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_PRBS7;
            gen_q      <= '1;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
            chk_q      <= '1;
            seed_cnt_q <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            locked_q   <= 1'b0;
            err_cnt_q  <= '0;
            err_sat_q  <= 1'b0;
        end else if (ena) begin
            mode_q     <= mode_d;
            gen_q      <= gen_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            state_q    <= state_d;
            chk_q      <= chk_d;
            seed_cnt_q <= seed_cnt_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            locked_q   <= locked_d;
            err_cnt_q  <= err_cnt_d;
            err_sat_q  <= err_sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_SEED;
        end else if (lnk.rx_valid) begin
            case (state_q)
                ST_SEED:   if (seed_done) state_d = ST_VERIFY;
                ST_VERIFY: begin
                    if (mismatch)      state_d = ST_SEED;
                    else if (lock_hit) state_d = ST_LOCKED;
                end
                ST_LOCKED: if (mismatch && loss_hit) state_d = ST_SEED;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        mode_d     = mode_q;
        gen_d      = gen_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (stop) begin
            tx_valid_d = 1'b0;
        end else if (start) begin
            mode_d     = mode_e'(mode);
            gen_d      = gen_next;
            tx_data_d  = gen_word ^ inj_mask;
            tx_valid_d = 1'b1;
        end else if (tx_valid_q) begin
            gen_d     = gen_next;
            tx_data_d = gen_word ^ inj_mask;
        end
    end

    always_comb begin
        chk_d      = chk_q;
        seed_cnt_d = seed_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        locked_d   = locked_q;
        err_cnt_d  = err_cnt_q;
        err_sat_d  = err_sat_q;
        if (go) begin
            seed_cnt_d = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            locked_d   = 1'b0;
            err_cnt_d  = '0;
            err_sat_d  = 1'b0;
        end else if (rx_step) begin
            case (state_q)
                ST_SEED: begin
                    chk_d      = chk_seed;
                    seed_cnt_d = seed_done ? '0 : seed_cnt_q + 3'd1;
                    good_cnt_d = '0;
                end
                ST_VERIFY: begin
                    if (mismatch) begin
                        seed_cnt_d = '0;
                    end else begin
                        chk_d      = chk_next;
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                        bad_cnt_d  = '0;
                        if (lock_hit) locked_d = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    chk_d = chk_next;
                    if (err_sum >= ERR_MAX) begin
                        err_cnt_d = '1;
                        err_sat_d = 1'b1;
                    end else begin
                        err_cnt_d = ERR_CNT_W'(err_sum);
                    end
                    if (!mismatch) begin
                        bad_cnt_d = '0;
                    end else if (loss_hit) begin
                        bad_cnt_d  = '0;
                        seed_cnt_d = '0;
                        locked_d   = 1'b0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + BAD_W'(1);
                    end
                end
                default: chk_d = chk_q;
            endcase
        end
    end

    always_comb begin
        lnk.tx_data  = tx_data_q;
        lnk.tx_valid = tx_valid_q;
        locked       = locked_q;
        err_cnt      = err_cnt_q;
        err_sat      = err_sat_q;
        state        = state_q;
    end

endmodule

// File: doc/serdes_prbs_bist.md
Name: serdes_prbs_bist

Overview:
Parametrised PRBS built-in self-test engine for the SerDes PHY. It drives pseudo-random parallel words into the TX serializer and checks parallel words returned from the RX deserializer, typically in loopback. It self-synchronises, tracks lock, and accumulates bit errors. It supersedes the fixed loopback harness and adds selectable polynomial, lock/loss hysteresis, error injection and a saturating error counter.

Parameters:
DATA_W, 8, parallel word width in bits; legal range 8..32.
ERR_CNT_W, 16, width of the bit-error counter.
LOCK_THRESH, 8, number of consecutive error-free words needed to declare lock.
LOSS_THRESH, 4, number of consecutive errored words needed to drop lock.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable; when low, all state holds
mode  in  2  polynomial select: 0=PRBS7 (x^7+x^6+1), 1=PRBS15 (x^15+x^14+1), 2=PRBS31 (x^31+x^28+1), 3=reserved, treated as PRBS7
start  in  1  single-cycle pulse: clear counters, seed, begin
stop  in  1  single-cycle pulse: return to IDLE
inject_err  in  1  single-cycle pulse: corrupt the next TX word
tx_data  out  DATA_W  generated word; bit DATA_W-1 is first on the line
tx_valid  out  1  tx_data valid
rx_data  in  DATA_W  received word, same bit order as tx_data
rx_valid  in  1  rx_data valid
locked  out  1  checker locked
err_cnt  out  ERR_CNT_W  accumulated bit errors
err_sat  out  1  sticky flag: err_cnt has saturated
state  out  2  checker state: 0=IDLE, 1=SEED, 2=VERIFY, 3=LOCKED

Behaviour:
- Reset values: tx_data=0, tx_valid=0, locked=0, err_cnt=0, err_sat=0, state=IDLE. Both LFSRs reset to all-ones.
- ena low: every register holds its value.
- LFSR rule (Fibonacci form): feedback bit = XOR of the two taps; the state shifts left and the feedback bit enters at bit 0. The output bit is the feedback bit. Each cycle advances the LFSR by DATA_W steps, and the first generated bit is placed at the MSB.
- mode is sampled only on start; mode changes at any other time are ignored.
- Generator, start: reload LFSR with all-ones, latch mode. The first word appears registered in the cycle after start, with tx_valid=1. After that, one word per cycle until stop; on stop, tx_valid=0 the next cycle.
- inject_err: XOR bit 0 of the next emitted word only. The LFSR sequence itself is unaffected. A pulse while tx_valid=0 is dropped.
- Checker FSM, advancing only on cycles with rx_valid=1:
  - IDLE: wait for start.
  - start (from any state): clear err_cnt and err_sat, move to SEED.
  - SEED: shift received bits into the checker LFSR until ORDER bits are collected (ceil(ORDER/DATA_W) words), then move to VERIFY with good_cnt=0.
  - VERIFY: compare rx_data against the predicted word.
    - Match: good_cnt++. On reaching LOCK_THRESH, move to LOCKED and set locked=1 on the next cycle.
    - Mismatch: return to SEED.
    - err_cnt is not updated in this state.
  - LOCKED: err_cnt += popcount(rx_data XOR predicted), saturating at all-ones.
    - Saturation sets err_sat, which is sticky until the next start.
    - The checker LFSR free-runs (no reseed).
    - bad_cnt counts consecutive errored words and resets on any clean word. When bad_cnt reaches LOSS_THRESH: locked=0, move to SEED.
- stop: return to IDLE. locked, err_cnt and err_sat hold their values for readout.
- Simultaneous start and stop: stop wins.
- rx_valid=0: checker state and counters hold, with no prediction advance.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Package serdes_bist_pkg holds:
  - mode encoding constants;
  - checker state encoding;
  - per-mode ORDER and tap positions;
  - a popcount function.
- One sub-module, prbs_lfsr_adv: combinational DATA_W-step advance of a 31-bit state with mode-selected taps, producing the next state and the output word. It is instantiated twice, once for the generator and once for the checker.

Test Plan:
1. Reset, then start with mode=0 and DATA_W=8 -> tx_data=0x02 and then 0x0C on consecutive cycles, with tx_valid=1.
2. Loopback (rx_data=tx_data, rx_valid=tx_valid), mode=0 -> state goes SEED, then VERIFY, then LOCKED; locked=1 exactly 1 seed word + 8 verify words after the first rx_valid; err_cnt stays 0.
3. While locked, pulse inject_err 3 times at separate cycles -> err_cnt=3 and locked stays 1.
4. While locked, force rx_data=~tx_data for 4 words -> err_cnt=32, then locked=0 and state=SEED; after rx_data is restored, lock is regained and err_cnt holds 32.
5. Run with ERR_CNT_W=4 and random rx_data while locked -> err_cnt sticks at 15 and err_sat=1; a new start clears both.
6. mode=1 and mode=2 loopback, plus assert rst_n low mid-LOCKED -> lock is achieved for both modes; on reset all outputs return to zero at once and tx_valid=0.
